dm_mmio_responder: RTL and testbench

- Memory-mapped I/O responder on both CPU data-memory ports (p0, p1), in parallel with the shared dual-port data RAM.
- Claims every access with maddr[8]=1 (0x100-0x1FF); the RAM keeps maddr[8]=0.
- Provides switches, key-press event flags, LEDs, six 7-segment digits and a 32-bit cycle timer.
- Read timing matches the RAM: registered data one cycle after the address, plus a registered hit flag so the top level can mux each port's rdata between RAM q and this block.

---
 rtl/dm_mmio_pkg.sv | 21 ++
 rtl/dm_mmio_responder_seg7_decoder.sv | 12 +
 rtl/dm_mmio_responder.sv | 168 ++++++++++++++++
 tb/tb_dm_mmio_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dm_mmio_pkg.sv
// Shared constants for the data-memory MMIO responder: register offsets and
// the active-low 7-segment encoding used by the HEX digits.
package dm_mmio_pkg;

    localparam logic [7:0] MMIO_SW    = 8'h00;
    localparam logic [7:0] MMIO_KEYEV = 8'h01;
    localparam logic [7:0] MMIO_LEDR  = 8'h02;
    localparam logic [7:0] MMIO_HEXLO = 8'h03;
    localparam logic [7:0] MMIO_HEXHI = 8'h04;
    localparam logic [7:0] MMIO_TMRLO = 8'h05;
    localparam logic [7:0] MMIO_TMRHI = 8'h06;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit 0 is segment a, bit 6 is segment g; a 0 lights the segment.
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/dm_mmio_responder_seg7_decoder.sv
// Combinational hex nibble to active-low 7-segment decoder with blanking.
import dm_mmio_pkg::*;

module seg7_decoder (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_CODES[nibble];

endmodule

// File: rtl/dm_mmio_responder.sv
// MMIO responder sitting beside the dual-port data RAM: claims addresses with
// the top address bit set and serves switches, key events, LEDs, HEX and a timer.
import dm_mmio_pkg::*;

module dm_mmio_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_maddr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_write_mem,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_io_hit,
    input  logic [ADDR_W-1:0] p1_maddr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_write_mem,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_io_hit,
    input  logic [9:0]        SW,
    input  logic [3:0]        KEY,
    output logic [9:0]        LEDR,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5
);

    logic [7:0]        offset [2];
    logic [DATA_W-1:0] wdata  [2];
    logic [DATA_W-1:0] rd_val [2];
    logic [DATA_W-1:0] rdata_q [2];
    logic [1:0]        hit, wr, rd, hit_q;

    logic [SYNC_STAGES-1:0][9:0] sw_pipe;
    logic [SYNC_STAGES-1:0][3:0] key_pipe;
    logic [9:0]  sw_sync;
    logic [3:0]  key_sync, key_prev, press, flags;
    logic [9:0]  ledr_q;
    logic [15:0] hex_lo;
    logic [7:0]  hex_hi;
    logic [5:0]  blank;
    logic [31:0] counter;
    logic [15:0] shadow;
    logic        key_clear, tmr_clear, tmr_latch;

    assign offset[0] = p0_maddr[7:0];
    assign offset[1] = p1_maddr[7:0];
    assign wdata[0]  = p0_wdata;
    assign wdata[1]  = p1_wdata;
    assign hit       = {p1_maddr[ADDR_W-1], p0_maddr[ADDR_W-1]};
    assign wr        = hit & {p1_write_mem, p0_write_mem};
    // Side effects (flag clear, shadow latch) only come from non-write accesses.
    assign rd        = hit & ~{p1_write_mem, p0_write_mem};

    assign sw_sync  = sw_pipe[SYNC_STAGES-1];
    assign key_sync = key_pipe[SYNC_STAGES-1];
    assign press    = key_prev & ~key_sync;

    always_comb begin
        key_clear = 1'b0;
        tmr_clear = 1'b0;
        tmr_latch = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (rd[p] && offset[p] == MMIO_KEYEV) key_clear = 1'b1;
            if (rd[p] && offset[p] == MMIO_TMRLO) tmr_latch = 1'b1;
            if (wr[p] && offset[p] == MMIO_TMRLO) tmr_clear = 1'b1;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = '0;
            case (offset[p])
                MMIO_SW:    rd_val[p] = DATA_W'(sw_sync);
                MMIO_KEYEV: rd_val[p] = DATA_W'(flags);
                MMIO_LEDR:  rd_val[p] = DATA_W'(ledr_q);
                MMIO_HEXLO: rd_val[p] = DATA_W'(hex_lo);
                MMIO_HEXHI: rd_val[p] = DATA_W'({blank, hex_hi});
                MMIO_TMRLO: rd_val[p] = DATA_W'(counter[15:0]);
                MMIO_TMRHI: rd_val[p] = DATA_W'(shadow);
                default:    rd_val[p] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_pipe  <= '0;
            key_pipe <= '1;
            key_prev <= '1;
            flags    <= '0;
        end else begin
            sw_pipe  <= {sw_pipe[SYNC_STAGES-2:0], SW};
            key_pipe <= {key_pipe[SYNC_STAGES-2:0], KEY};
            key_prev <= key_sync;
            flags    <= (key_clear ? 4'b0 : flags) | press;
        end
    end

    // Port 1 is visited last, so its write wins when both ports hit one register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ledr_q <= '0;
            hex_lo <= '0;
            hex_hi <= '0;
            blank  <= 6'h3F;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr[p]) begin
                    case (offset[p])
                        MMIO_LEDR:  ledr_q <= wdata[p][9:0];
                        MMIO_HEXLO: hex_lo <= wdata[p][15:0];
                        MMIO_HEXHI: begin
                            hex_hi <= wdata[p][7:0];
                            blank  <= wdata[p][13:8];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            shadow  <= '0;
        end else begin
            counter <= tmr_clear ? 32'd0 : counter + 32'd1;
            if (tmr_latch) shadow <= counter[31:16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            hit_q <= hit;
            for (int p = 0; p < 2; p++) begin
                rdata_q[p] <= hit[p] ? rd_val[p] : '0;
            end
        end
    end

    assign p0_rdata  = rdata_q[0];
    assign p1_rdata  = rdata_q[1];
    assign p0_io_hit = hit_q[0];
    assign p1_io_hit = hit_q[1];
    assign LEDR      = ledr_q;

    logic unused_bits;
    assign unused_bits = ^{p0_wdata[DATA_W-1:14], p1_wdata[DATA_W-1:14]};

    seg7_decoder u_hex0 (.nibble(hex_lo[3:0]),   .blank(blank[0]), .seg(HEX0));
    seg7_decoder u_hex1 (.nibble(hex_lo[7:4]),   .blank(blank[1]), .seg(HEX1));
    seg7_decoder u_hex2 (.nibble(hex_lo[11:8]),  .blank(blank[2]), .seg(HEX2));
    seg7_decoder u_hex3 (.nibble(hex_lo[15:12]), .blank(blank[3]), .seg(HEX3));
    seg7_decoder u_hex4 (.nibble(hex_hi[3:0]),   .blank(blank[4]), .seg(HEX4));
    seg7_decoder u_hex5 (.nibble(hex_hi[7:4]),   .blank(blank[5]), .seg(HEX5));

endmodule

// File: tb/tb_dm_mmio_responder.sv
// Directed bench for dm_mmio_responder: inputs change on the falling edge and
// outputs are checked on the following falling edge.
module tb_dm_mmio_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  p0_maddr, p1_maddr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_write_mem, p1_write_mem;
    logic [15:0] p0_rdata, p1_rdata;
    logic        p0_io_hit, p1_io_hit;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [9:0]  LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_mmio_responder dut (
        .clk(clk), .rst(rst),
        .p0_maddr(p0_maddr), .p0_wdata(p0_wdata), .p0_write_mem(p0_write_mem),
        .p0_rdata(p0_rdata), .p0_io_hit(p0_io_hit),
        .p1_maddr(p1_maddr), .p1_wdata(p1_wdata), .p1_write_mem(p1_write_mem),
        .p1_rdata(p1_rdata), .p1_io_hit(p1_io_hit),
        .SW(SW), .KEY(KEY), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive both ports now, return on the next falling edge.
    task automatic applyStimulus(input logic [8:0] a0, input logic [15:0] d0, input logic w0,
                                 input logic [8:0] a1, input logic [15:0] d1, input logic w1);
        p0_maddr = a0; p0_wdata = d0; p0_write_mem = w0;
        p1_maddr = a1; p1_wdata = d1; p1_write_mem = w1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(9'h000, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        SW  = 10'h0;
        KEY = 4'hF;
        p0_maddr = '0; p0_wdata = '0; p0_write_mem = 1'b0;
        p1_maddr = '0; p1_wdata = '0; p1_write_mem = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_p0_rdata", p0_rdata, 0);
        checkOutput("rst_p0_hit", p0_io_hit, 0);
        checkOutput("rst_hex3", HEX3, 7'h7F);
        rst = 1'b0;

        // Reset values and read latency
        applyStimulus(9'h102, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        checkOutput("ledr_read", p0_rdata, 16'h0000);
        checkOutput("ledr_hit", p0_io_hit, 1);
        checkOutput("hex0_blank", HEX0, 7'h7F);
        checkOutput("hex5_blank", HEX5, 7'h7F);
        checkOutput("ledr_reset", LEDR, 10'h000);

        // LED writes, dual-write conflict and read-before-write
        applyStimulus(9'h102, 16'h02A5, 1'b1, 9'h000, 16'h0, 1'b0);
        checkOutput("ledr_wr", LEDR, 10'h2A5);
        applyStimulus(9'h102, 16'h0011, 1'b1, 9'h102, 16'h0022, 1'b1);
        checkOutput("ledr_p1_wins", LEDR, 10'h022);
        applyStimulus(9'h102, 16'h0155, 1'b1, 9'h102, 16'h0, 1'b0);
        checkOutput("ledr_rbw", p1_rdata, 16'h0022);
        checkOutput("ledr_rbw_hit", p1_io_hit, 1);
        checkOutput("ledr_new", LEDR, 10'h155);

        // Switches through the synchronizer
        SW = 10'h2B3;
        idle(3);
        applyStimulus(9'h100, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        checkOutput("sw_read", p0_rdata, 16'h02B3);

        // Key press flag, read-clear, press coincident with clear
        KEY = 4'b1011;
        idle(10);
        applyStimulus(9'h101, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        checkOutput("key_flag", p0_rdata, 16'h0004);
        applyStimulus(9'h101, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        checkOutput("key_cleared", p0_rdata, 16'h0000);
        KEY = 4'hF;
        idle(4);
        KEY = 4'b1011;
        idle(2);
        applyStimulus(9'h101, 16'h0, 1'b0, 9'h101, 16'h0, 1'b0);
        checkOutput("key_coinc_p0", p0_rdata, 16'h0000);
        checkOutput("key_coinc_p1", p1_rdata, 16'h0000);
        applyStimulus(9'h101, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        checkOutput("key_kept", p0_rdata, 16'h0004);

        // HEX digits and blanking
        applyStimulus(9'h104, 16'h00B7, 1'b1, 9'h103, 16'h1234, 1'b1);
        checkOutput("hex5", HEX5, 7'h03);
        checkOutput("hex4", HEX4, 7'h78);
        checkOutput("hex3", HEX3, 7'h79);
        checkOutput("hex2", HEX2, 7'h24);
        checkOutput("hex1", HEX1, 7'h30);
        checkOutput("hex0", HEX0, 7'h19);
        applyStimulus(9'h103, 16'h0, 1'b0, 9'h104, 16'h0, 1'b0);
        checkOutput("hexlo_read", p0_rdata, 16'h1234);
        checkOutput("hexhi_read", p1_rdata, 16'h00B7);
        applyStimulus(9'h104, 16'h2000, 1'b1, 9'h000, 16'h0, 1'b0);
        checkOutput("hex5_masked", HEX5, 7'h7F);
        checkOutput("hex4_zero", HEX4, 7'h40);
        checkOutput("hex0_kept", HEX0, 7'h19);

        // Timer: clear, count 100, then read at 0x0001_0000 to latch the high half
        applyStimulus(9'h105, 16'h0, 1'b1, 9'h000, 16'h0, 1'b0);
        idle(100);
        applyStimulus(9'h105, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        checkOutput("tmr_100", p0_rdata, 16'd100);
        applyStimulus(9'h105, 16'h0, 1'b1, 9'h000, 16'h0, 1'b0);
        idle(65536);
        applyStimulus(9'h105, 16'h0, 1'b0, 9'h105, 16'h0, 1'b0);
        checkOutput("tmrlo_p0", p0_rdata, 16'h0000);
        checkOutput("tmrlo_p1", p1_rdata, 16'h0000);
        idle(5);
        applyStimulus(9'h106, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        checkOutput("tmrhi_shadow", p0_rdata, 16'h0001);

        // RAM space and unmapped offsets
        applyStimulus(9'h000, 16'h0, 1'b0, 9'h0FF, 16'h0, 1'b0);
        checkOutput("ram_hit", p1_io_hit, 0);
        checkOutput("ram_rdata", p1_rdata, 16'h0000);
        applyStimulus(9'h1F0, 16'h03FF, 1'b1, 9'h000, 16'h0, 1'b0);
        applyStimulus(9'h1F0, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        checkOutput("unmapped_read", p0_rdata, 16'h0000);
        checkOutput("unmapped_hit", p0_io_hit, 1);
        checkOutput("unmapped_ledr", LEDR, 10'h155);

        // Reset asserted during a write aborts it
        p0_maddr = 9'h102; p0_wdata = 16'h03FF; p0_write_mem = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        p0_maddr = 9'h000; p0_write_mem = 1'b0;
        checkOutput("rst_ledr", LEDR, 10'h000);
        checkOutput("rst_hex0", HEX0, 7'h7F);
        rst = 1'b0;
        idle(2);
        checkOutput("post_rst_ledr", LEDR, 10'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
